// File: rtl/prescaled_counter.sv
// ---------------------------------------------------------------------------
// prescaled_counter
//
// Event counter with a run-time programmable prescaler, up/down direction,
// load/clear and wrap / saturate / one-shot terminal behaviour. Intended for
// timer, watchdog and rate-divider use on the single core clock domain.
//
// Optional feature macro: PRESCALED_COUNTER_CAPTURE_EN
//   When defined, adds capture_i / capture_o. capture_o takes the pre-update
//   count on any edge where capture_i is high (including clear/load edges).
//
// Ports
//   clock_i       in   1               core clock, posedge
//   reset_i       in   1               synchronous, active-high reset
//   enable_i      in   1               advance the prescaler when high
//   clear_i       in   1               count<=0, prescaler<=0, re-arm one-shot
//   load_i        in   1               count<=load_value_i, prescaler<=0, re-arm
//   load_value_i  in   COUNT_WIDTH     value taken on load_i
//   prescale_i    in   PRESCALE_WIDTH  step every prescale_i+1 enabled cycles
//   dir_i         in   1               0 = up, 1 = down
//   mode_i        in   2               00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   limit_i       in   COUNT_WIDTH     up-count terminal (down terminal is 0)
//   count_o       out  COUNT_WIDTH     current count (registered)
//   tick_o        out  1               pulse: a step was taken this edge
//   terminal_o    out  1               pulse: the step was taken at terminal
//   running_o     out  1               one-shot armed; 1 outside one-shot mode
//   capture_i     in   1               (capture build only) snapshot request
//   capture_o     out  COUNT_WIDTH     (capture build only) snapshot register
// ---------------------------------------------------------------------------
module prescaled_counter #(
    parameter int unsigned COUNT_WIDTH    = 16,
    parameter int unsigned PRESCALE_WIDTH = 8
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      enable_i,
    input  logic                      clear_i,
    input  logic                      load_i,
    input  logic [COUNT_WIDTH-1:0]    load_value_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    input  logic                      dir_i,
    input  logic [1:0]                mode_i,
    input  logic [COUNT_WIDTH-1:0]    limit_i,
`ifdef PRESCALED_COUNTER_CAPTURE_EN
    input  logic                      capture_i,
    output logic [COUNT_WIDTH-1:0]    capture_o,
`endif
    output logic [COUNT_WIDTH-1:0]    count_o,
    output logic                      tick_o,
    output logic                      terminal_o,
    output logic                      running_o
);

    localparam int unsigned CW = COUNT_WIDTH;
    localparam int unsigned PW = PRESCALE_WIDTH;

    localparam logic [1:0] MODE_WRAP     = 2'b00;
    localparam logic [1:0] MODE_SATURATE = 2'b01;
    localparam logic [1:0] MODE_ONESHOT  = 2'b10;

    // What a step does to the count register.
    typedef enum logic [2:0] {
        ACT_HOLD       = 3'd0,
        ACT_INC        = 3'd1,
        ACT_DEC        = 3'd2,
        ACT_WRAP_ZERO  = 3'd3,
        ACT_WRAP_LIMIT = 3'd4,
        ACT_STOP       = 3'd5
    } step_act_e;

    // Registered state
    logic [CW-1:0] count_q,    count_d;
    logic [PW-1:0] presc_q,    presc_d;
    logic          tick_q,     tick_d;
    logic          terminal_q, terminal_d;
    logic          running_q,  running_d;

    // Combinational helpers
    logic      step_en_c;
    logic      presc_done_c;
    logic      at_terminal_c;
    step_act_e step_act_c;

    // Step qualification: prescaler only advances while enabled and armed.
    // ">=" lets a lowered prescale_i take effect on the next enabled cycle.
    always_comb begin
        step_en_c    = enable_i & running_q;
        presc_done_c = (presc_q >= prescale_i);
    end

    // Terminal detection; ">=" on the up side also catches loads above limit.
    always_comb begin
        at_terminal_c = 1'b0;
        if (dir_i) begin
            at_terminal_c = (count_q == CW'(0));
        end else begin
            at_terminal_c = (count_q >= limit_i);
        end
    end

    // Decide what a step does given direction, terminal state and mode.
    always_comb begin
        step_act_c = ACT_HOLD;
        if (!at_terminal_c) begin
            step_act_c = dir_i ? ACT_DEC : ACT_INC;
        end else begin
            unique case (mode_i)
                MODE_SATURATE: step_act_c = ACT_HOLD;
                MODE_ONESHOT:  step_act_c = ACT_STOP;
                default:       step_act_c = dir_i ? ACT_WRAP_LIMIT : ACT_WRAP_ZERO;
            endcase
        end
    end

    // Next-state logic; priority clear > load > step (reset is in the register).
    always_comb begin
        count_d    = count_q;
        presc_d    = presc_q;
        tick_d     = 1'b0;
        terminal_d = 1'b0;
        running_d  = running_q;

        // Leaving one-shot mode re-arms so the other modes always run.
        if (mode_i != MODE_ONESHOT) begin
            running_d = 1'b1;
        end

        if (clear_i) begin
            count_d   = CW'(0);
            presc_d   = PW'(0);
            running_d = 1'b1;
        end else if (load_i) begin
            count_d   = load_value_i;
            presc_d   = PW'(0);
            running_d = 1'b1;
        end else if (step_en_c) begin
            if (presc_done_c) begin
                presc_d    = PW'(0);
                tick_d     = 1'b1;
                terminal_d = at_terminal_c;
                unique case (step_act_c)
                    ACT_INC:        count_d = count_q + CW'(1);
                    ACT_DEC:        count_d = count_q - CW'(1);
                    ACT_WRAP_ZERO:  count_d = CW'(0);
                    ACT_WRAP_LIMIT: count_d = limit_i;
                    ACT_STOP:       running_d = 1'b0;
                    default:        count_d = count_q;
                endcase
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // State register
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            count_q    <= CW'(0);
            presc_q    <= PW'(0);
            tick_q     <= 1'b0;
            terminal_q <= 1'b0;
            running_q  <= 1'b1;
        end else begin
            count_q    <= count_d;
            presc_q    <= presc_d;
            tick_q     <= tick_d;
            terminal_q <= terminal_d;
            running_q  <= running_d;
        end
    end

`ifdef PRESCALED_COUNTER_CAPTURE_EN
    // Snapshot of the count as it stood before this edge's update.
    logic [CW-1:0] capture_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            capture_q <= CW'(0);
        end else if (capture_i) begin
            capture_q <= count_q;
        end
    end

    assign capture_o = capture_q;
`endif

    assign count_o    = count_q;
    assign tick_o     = tick_q;
    assign terminal_o = terminal_q;
    assign running_o  = running_q;

endmodule

// File: tb/tb_prescaled_counter.sv
// ---------------------------------------------------------------------------
// tb_prescaled_counter
//
// Table-driven bench for prescaled_counter. Each vector holds the inputs for
// one clock edge and the outputs expected after it; expected records are
// queued when a vector is driven and popped when the outputs are sampled.
// A hand-written sequence checks the full-scale prescale period.
// Build with PRESCALED_COUNTER_CAPTURE_EN defined to also cover capture.
// ---------------------------------------------------------------------------
module tb_prescaled_counter;

    localparam int unsigned CW = 16;
    localparam int unsigned PW = 8;

    logic          clock;
    logic          reset;
    logic          enable;
    logic          clear;
    logic          load;
    logic [CW-1:0] load_value;
    logic [PW-1:0] prescale;
    logic          dir;
    logic [1:0]    mode;
    logic [CW-1:0] limit;
    logic [CW-1:0] count;
    logic          tick;
    logic          terminal;
    logic          running;
    logic          capture;
    logic [CW-1:0] capture_val;

    prescaled_counter #(
        .COUNT_WIDTH    (CW),
        .PRESCALE_WIDTH (PW)
    ) dut (
        .clock_i      (clock),
        .reset_i      (reset),
        .enable_i     (enable),
        .clear_i      (clear),
        .load_i       (load),
        .load_value_i (load_value),
        .prescale_i   (prescale),
        .dir_i        (dir),
        .mode_i       (mode),
        .limit_i      (limit),
`ifdef PRESCALED_COUNTER_CAPTURE_EN
        .capture_i    (capture),
        .capture_o    (capture_val),
`endif
        .count_o      (count),
        .tick_o       (tick),
        .terminal_o   (terminal),
        .running_o    (running)
    );

`ifndef PRESCALED_COUNTER_CAPTURE_EN
    assign capture_val = '0;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          rst, clr, ld, en;
        logic [CW-1:0] ldv;
        logic [PW-1:0] pre;
        bit          dir;
        logic [1:0]  mode;
        logic [CW-1:0] lim;
        bit          cap;
        logic [CW-1:0] e_count;
        bit          e_tick, e_term, e_run;
        bit          chk_cap;
        logic [CW-1:0] e_cap;
    } vec_t;

    typedef struct {
        int            idx;
        logic [CW-1:0] count;
        bit            tick, term, run;
        bit            chk_cap;
        logic [CW-1:0] cap;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(input bit rst, clr, ld, en, input int ldv, pre,
                                input bit d, input bit [1:0] m, input int lim,
                                input bit cap, input int ec, input bit et, eterm, er,
                                input bit chk_cap = 1'b0, input int ecap = 0);
        vec_t v;
        v.rst = rst; v.clr = clr; v.ld = ld; v.en = en;
        v.ldv = 16'(ldv); v.pre = 8'(pre); v.dir = d; v.mode = m;
        v.lim = 16'(lim); v.cap = cap;
        v.e_count = 16'(ec); v.e_tick = et; v.e_term = eterm; v.e_run = er;
        v.chk_cap = chk_cap; v.e_cap = 16'(ecap);
        vecs.push_back(v);
    endfunction

    // Plain step vector: no reset/clear/load/capture.
    function automatic void stp(input bit en, input int pre, input bit d,
                                input bit [1:0] m, input int lim,
                                input int ec, input bit et, eterm, er);
        add(0, 0, 0, en, 0, pre, d, m, lim, 0, ec, et, eterm, er);
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0d want %0d", name, idx, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        int   n;

        reset = 1'b1; enable = 0; clear = 0; load = 0; load_value = '0;
        prescale = '0; dir = 0; mode = 2'b00; limit = '0; capture = 0;

        // Reset
        add(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0);
        add(1, 1, 1, 1, 5, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0);

        // Up wrap, prescale 3, limit 5: step every 4th edge, 0..5,0,1
        for (int k = 1; k <= 30; k++) begin
            stp(1, 3, 0, 2'b00, 5, (k / 4) % 6, (k % 4) == 0, k == 24, 1);
        end

        // Down saturate from 2 with prescale 0
        add(0, 0, 1, 1, 2, 0, 1, 2'b01, 5, 0, 2, 0, 0, 1);
        stp(1, 0, 1, 2'b01, 5, 1, 1, 0, 1);
        stp(1, 0, 1, 2'b01, 5, 0, 1, 0, 1);
        stp(1, 0, 1, 2'b01, 5, 0, 1, 1, 1);
        stp(1, 0, 1, 2'b01, 5, 0, 1, 1, 1);

        // One-shot up to 3, prescale 1
        add(0, 1, 0, 0, 0, 1, 0, 2'b10, 3, 0, 0, 0, 0, 1);
        stp(1, 1, 0, 2'b10, 3, 0, 0, 0, 1);
        stp(1, 1, 0, 2'b10, 3, 1, 1, 0, 1);
        stp(1, 1, 0, 2'b10, 3, 1, 0, 0, 1);
        stp(1, 1, 0, 2'b10, 3, 2, 1, 0, 1);
        stp(1, 1, 0, 2'b10, 3, 2, 0, 0, 1);
        stp(1, 1, 0, 2'b10, 3, 3, 1, 0, 1);
        stp(1, 1, 0, 2'b10, 3, 3, 0, 0, 1);
        stp(1, 1, 0, 2'b10, 3, 3, 1, 1, 0);
        stp(1, 1, 0, 2'b10, 3, 3, 0, 0, 0);
        stp(1, 1, 0, 2'b10, 3, 3, 0, 0, 0);
        // Load re-arms and the one-shot resumes from 1
        add(0, 0, 1, 1, 1, 1, 0, 2'b10, 3, 0, 1, 0, 0, 1);
        stp(1, 1, 0, 2'b10, 3, 1, 0, 0, 1);
        stp(1, 1, 0, 2'b10, 3, 2, 1, 0, 1);
        stp(1, 1, 0, 2'b10, 3, 2, 0, 0, 1);
        stp(1, 1, 0, 2'b10, 3, 3, 1, 0, 1);
        stp(1, 1, 0, 2'b10, 3, 3, 0, 0, 1);
        stp(1, 1, 0, 2'b10, 3, 3, 1, 1, 0);
        stp(1, 1, 0, 2'b10, 3, 3, 0, 0, 0);
        // Leaving one-shot mode re-arms; enable low holds
        stp(0, 1, 0, 2'b00, 3, 3, 0, 0, 1);

        // Clear/load priority and reset priority
        add(0, 0, 1, 1, 10, 0, 0, 2'b00, 100, 0, 10, 0, 0, 1);
        stp(1, 0, 0, 2'b00, 100, 11, 1, 0, 1);
        add(0, 1, 1, 1, 50, 0, 0, 2'b00, 100, 0, 0, 0, 0, 1);
        stp(1, 0, 0, 2'b00, 100, 1, 1, 0, 1);
        add(1, 1, 1, 1, 77, 0, 0, 2'b00, 100, 1, 0, 0, 0, 1, 1, 0);

        // Load above limit is terminal on the next up step
        add(0, 0, 1, 0, 200, 0, 0, 2'b00, 100, 0, 200, 0, 0, 1);
        stp(1, 0, 0, 2'b00, 100, 0, 1, 1, 1);
        // limit 0 up wrap: stuck at 0, terminal each tick
        stp(1, 0, 0, 2'b00, 0, 0, 1, 1, 1);
        stp(1, 0, 0, 2'b00, 0, 0, 1, 1, 1);
        // Down wrap from 0 reloads limit
        stp(1, 0, 1, 2'b00, 7, 7, 1, 1, 1);
        stp(1, 0, 1, 2'b00, 7, 6, 1, 0, 1);
        // Mode 11 behaves as wrap
        stp(1, 0, 0, 2'b11, 6, 0, 1, 1, 1);

        // Prescale lowered 7 -> 1 with prescaler at 5; enable gaps hold
        add(0, 1, 0, 0, 0, 7, 0, 2'b00, 100, 0, 0, 0, 0, 1);
        stp(1, 7, 0, 2'b00, 100, 0, 0, 0, 1);
        stp(1, 7, 0, 2'b00, 100, 0, 0, 0, 1);
        stp(1, 7, 0, 2'b00, 100, 0, 0, 0, 1);
        stp(0, 7, 0, 2'b00, 100, 0, 0, 0, 1);
        stp(0, 7, 0, 2'b00, 100, 0, 0, 0, 1);
        stp(1, 7, 0, 2'b00, 100, 0, 0, 0, 1);
        stp(1, 7, 0, 2'b00, 100, 0, 0, 0, 1);
        stp(1, 1, 0, 2'b00, 100, 1, 1, 0, 1);
        stp(1, 1, 0, 2'b00, 100, 1, 0, 0, 1);
        stp(1, 1, 0, 2'b00, 100, 2, 1, 0, 1);
        stp(1, 1, 0, 2'b00, 100, 2, 0, 0, 1);
        stp(1, 1, 0, 2'b00, 100, 3, 1, 0, 1);

`ifdef PRESCALED_COUNTER_CAPTURE_EN
        // Capture takes the pre-update count on step and load edges
        add(0, 0, 1, 0, 9, 0, 0, 2'b00, 100, 0, 9, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0, 2'b00, 100, 1, 10, 1, 0, 1, 1, 9);
        add(0, 0, 1, 1, 20, 0, 0, 2'b00, 100, 1, 20, 0, 0, 1, 1, 10);
        add(0, 1, 0, 0, 0, 0, 0, 2'b00, 100, 1, 0, 0, 0, 1, 1, 20);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst; clear = vecs[i].clr; load = vecs[i].ld;
            enable = vecs[i].en; load_value = vecs[i].ldv;
            prescale = vecs[i].pre; dir = vecs[i].dir; mode = vecs[i].mode;
            limit = vecs[i].lim; capture = vecs[i].cap;
            e.idx = i; e.count = vecs[i].e_count; e.tick = vecs[i].e_tick;
            e.term = vecs[i].e_term; e.run = vecs[i].e_run;
            e.chk_cap = vecs[i].chk_cap; e.cap = vecs[i].e_cap;
            sb.push_back(e);
            @(posedge clock);
            #1;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard vec %0d: got empty want entry", i);
            end else begin
                e = sb.pop_front();
                chk("count", e.idx, int'(count), int'(e.count));
                chk("tick", e.idx, int'(tick), int'(e.tick));
                chk("terminal", e.idx, int'(terminal), int'(e.term));
                chk("running", e.idx, int'(running), int'(e.run));
`ifdef PRESCALED_COUNTER_CAPTURE_EN
                if (e.chk_cap) chk("capture", e.idx, int'(capture_val), int'(e.cap));
`endif
            end
        end

        // Full-scale prescale: first tick exactly 256 enabled edges after clear
        reset = 0; load = 0; capture = 0; enable = 0; clear = 1;
        prescale = 8'd255; dir = 0; mode = 2'b00; limit = 16'd100;
        @(posedge clock);
        #1;
        clear = 0; enable = 1;
        n = 0;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clock);
            #1;
            if (tick) begin
                n = k;
                break;
            end
        end
        chk("full_prescale_period", 0, n, 256);
        chk("full_prescale_count", 0, int'(count), 1);
        enable = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
